uart_line_receiver: RTL
=======================

UART_LINE_RECEIVER -- requirements
Module: uart_line_receiver

Interface
REQ-001 SHALL have port clk, input, 1: single clock for all state.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port rx, input, 1: serial line from the UART tx pin; idle high.
REQ-004 SHALL have port divisor, input, 16: clk cycles per 1/16 bit time; a value of 0 is treated as 1.
REQ-005 SHALL have port char_len, input, 2: LCR[1:0] encoding, 0..3 selecting 5..8 data bits.
REQ-006 SHALL have port stop2, input, 1: LCR[2]; 1 selects two stop bits.
REQ-007 SHALL have port par_en, par_even, par_stick, inputs, 1 each: LCR[3], LCR[4], LCR[5].
REQ-008 SHALL have port rx_data, output, 8: received character, LSB-first assembled, upper bits zero.
REQ-009 SHALL have port rx_valid, output, 1: rx_data and the status flags are held valid.
REQ-010 SHALL have port rx_ready, input, 1: consumer accepts the character when rx_valid and rx_ready are both high.
REQ-011 SHALL have ports parity_err, framing_err, break_det, overrun, outputs, 1 each: status of the held character.

Function
REQ-012 SHALL run a tick counter that reloads from divisor and pulses tick once every divisor clk cycles.
REQ-013 SHALL synchronise rx through two flops; all decisions SHALL use the synchronised value.
REQ-014 SHALL implement the FSM IDLE -> START -> DATA -> PARITY -> STOP1 -> STOP2 -> IDLE.
REQ-015 IDLE: on a falling edge of the synchronised rx, SHALL clear the sample counter and enter START.
REQ-016 START: at 8 ticks, if rx is high it SHALL return to IDLE (glitch rejected); otherwise it SHALL continue.
REQ-017 Every later bit SHALL be sampled at tick 16 after the previous sample point (mid-bit).
REQ-018 DATA SHALL shift in char_len+5 bits, then go to PARITY if par_en, else to STOP1.
REQ-019 Parity SHALL be checked as follows: for stick parity, the expected bit is ~par_even; otherwise it is the XOR of the data bits XOR ~par_even; a mismatch sets parity_err.
REQ-020 STOP1: sampled 0 SHALL set framing_err; go to STOP2 if stop2, else complete.
REQ-021 STOP2: SHALL be sampled and ignored for framing (16550 behaviour), then complete.
REQ-022 break_det SHALL be set when all data bits, the parity bit and stop bit 1 all sample 0.
REQ-023 After a break, the FSM SHALL wait in IDLE for rx high before it re-arms edge detection.
REQ-024 On completion, the holding register SHALL load one cycle after the final sample and assert rx_valid.
REQ-025 When the holding register is full and not being accepted at completion, the new character SHALL be dropped, the old data SHALL be kept, and overrun SHALL be set.
REQ-026 When acceptance and completion occur in the same cycle, the new character SHALL load with rx_valid held high and no overrun.
REQ-027 Status flags SHALL clear on acceptance unless a new character loads in the same cycle.
REQ-028 A change to the configuration inputs mid-character is undefined; the bench SHALL change them only while IDLE.

Reset
REQ-029 Asserting rst_n low SHALL clear immediately: FSM to IDLE, all counters 0, both sync flops 1, rx_data 0, rx_valid 0, all status flags 0.
REQ-030 Reset during a character SHALL abandon it; the first edge seen after release SHALL start fresh.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the LCR bit-position constants, and OVERSAMPLE=16.
REQ-032 The block SHALL contain one sub-module, uart_baud_tick (divisor counter -> tick).

Verification
REQ-033 Scenario: divisor=1, 8N1, send 0xA5 -> rx_valid with rx_data=0xA5 after 160 ticks, all flags 0.
REQ-034 Scenario: 7E1, send 0x35 with wrong parity -> rx_data=0x35, parity_err=1.
REQ-035 Scenario: 8N1, stop bit driven 0 -> framing_err=1; line held 0 for 12 bits -> break_det=1, framing_err=1, rx_data=0x00.
REQ-036 Scenario: rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11, overrun=1; after acceptance, overrun=0.
REQ-037 Scenario: 4-tick low pulse on idle rx -> no rx_valid and FSM returns to IDLE.
REQ-038 Scenario: rst_n pulsed low mid-DATA, then 0x3C sent -> rx_data=0x3C received correctly, no flags set.

Source files
------------

// File: rtl/uart_line_receiver_pkg.sv
// Shared definitions for the UART line receiver: FSM encoding, LCR field
// positions and the oversampling ratio.
package uart_line_receiver_pkg;

    localparam int unsigned Oversample = 16;

    // LCR bit positions
    localparam int unsigned LcrWlsLsb   = 0;
    localparam int unsigned LcrStbBit   = 2;
    localparam int unsigned LcrPenBit   = 3;
    localparam int unsigned LcrEpsBit   = 4;
    localparam int unsigned LcrStickBit = 5;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop1  = 3'd4,
        StStop2  = 3'd5
    } rx_state_e;

    // Index of the last data bit for a word-length select (5..8 bits -> 4..7)
    function automatic logic [2:0] last_data_idx(input logic [1:0] wls);
        return {1'b0, wls} + 3'd4;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every `divisor` clocks
// (divisor 0 behaves as 1).
module uart_baud_tick (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] divisor,
    output logic        tick
);

    logic [15:0] cnt_q;
    logic [15:0] reload;

    assign reload = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
    assign tick   = (cnt_q == 16'd0);

    // Down-counter reloaded on every tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= reload;
        end else begin
            cnt_q <= cnt_q - 16'd1;
        end
    end

endmodule

// File: rtl/uart_line_receiver.sv
// UART receive path: 16x oversampled framing FSM feeding a one-entry
// holding register with ready/valid handshake and per-character status.
module uart_line_receiver
    import uart_line_receiver_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic [15:0] divisor,
    input  logic [1:0]  char_len,
    input  logic        stop2,
    input  logic        par_en,
    input  logic        par_even,
    input  logic        par_stick,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        parity_err,
    output logic        framing_err,
    output logic        break_det,
    output logic        overrun
);

    localparam logic [3:0] MidCnt  = 4'(Oversample / 2 - 1);
    localparam logic [3:0] LastCnt = 4'(Oversample - 1);

    logic [5:0] lcr;
    logic [2:0] last_idx;
    logic       stop2_cfg, par_en_cfg, par_even_cfg, par_stick_cfg;

    logic       tick;
    logic [1:0] sync_q;
    logic       rx_prev_q;
    logic       rx_s;
    logic       fall;

    rx_state_e  state_q;
    logic [3:0] cnt_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shift_q;
    logic       par_acc_q;
    logic       all_zero_q;
    logic       par_err_q;
    logic       frm_err_q;
    logic       brk_q;
    logic       wait_high_q;
    logic       done_q;
    logic       par_exp;
    logic       accept;

    assign lcr           = {par_stick, par_even, par_en, stop2, char_len};
    assign last_idx      = last_data_idx(lcr[LcrWlsLsb +: 2]);
    assign stop2_cfg     = lcr[LcrStbBit];
    assign par_en_cfg    = lcr[LcrPenBit];
    assign par_even_cfg  = lcr[LcrEpsBit];
    assign par_stick_cfg = lcr[LcrStickBit];

    assign rx_s    = sync_q[1];
    assign fall    = rx_prev_q & ~rx_s;
    assign par_exp = par_stick_cfg ? ~par_even_cfg : (par_acc_q ^ ~par_even_cfg);
    assign accept  = rx_valid & rx_ready;

    uart_baud_tick u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .divisor (divisor),
        .tick    (tick)
    );

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_prev_q <= sync_q[1];
        end
    end

    // Framing FSM: start validation, mid-bit sampling, parity/stop/break checks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            par_acc_q   <= 1'b0;
            all_zero_q  <= 1'b0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            brk_q       <= 1'b0;
            wait_high_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // After a break the line must return high before a new start counts
                    if (wait_high_q) begin
                        if (rx_s) wait_high_q <= 1'b0;
                    end else if (fall) begin
                        cnt_q   <= '0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (tick) begin
                        if (cnt_q == MidCnt) begin
                            cnt_q <= '0;
                            if (rx_s) begin
                                state_q <= StIdle;
                            end else begin
                                state_q    <= StData;
                                bit_idx_q  <= '0;
                                shift_q    <= '0;
                                par_acc_q  <= 1'b0;
                                all_zero_q <= 1'b1;
                                par_err_q  <= 1'b0;
                                frm_err_q  <= 1'b0;
                                brk_q      <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == LastCnt) begin
                            shift_q[bit_idx_q] <= rx_s;
                            par_acc_q          <= par_acc_q ^ rx_s;
                            all_zero_q         <= all_zero_q & ~rx_s;
                            bit_idx_q          <= bit_idx_q + 3'd1;
                            if (bit_idx_q == last_idx) begin
                                state_q <= par_en_cfg ? StParity : StStop1;
                            end
                        end
                    end
                end
                StParity: begin
                    if (tick) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == LastCnt) begin
                            par_err_q  <= rx_s ^ par_exp;
                            all_zero_q <= all_zero_q & ~rx_s;
                            state_q    <= StStop1;
                        end
                    end
                end
                StStop1: begin
                    if (tick) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == LastCnt) begin
                            frm_err_q <= ~rx_s;
                            brk_q     <= all_zero_q & ~rx_s;
                            if (stop2_cfg) begin
                                state_q <= StStop2;
                            end else begin
                                state_q     <= StIdle;
                                done_q      <= 1'b1;
                                wait_high_q <= all_zero_q & ~rx_s;
                            end
                        end
                    end
                end
                StStop2: begin
                    // Second stop bit is sampled but never flags a framing error
                    if (tick) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == LastCnt) begin
                            state_q     <= StIdle;
                            done_q      <= 1'b1;
                            wait_high_q <= brk_q;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Holding register: load on completion, drop with overrun when still full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            break_det   <= 1'b0;
            overrun     <= 1'b0;
        end else if (done_q && (!rx_valid || accept)) begin
            rx_data     <= shift_q;
            rx_valid    <= 1'b1;
            parity_err  <= par_err_q;
            framing_err <= frm_err_q;
            break_det   <= brk_q;
            overrun     <= 1'b0;
        end else if (done_q) begin
            overrun <= 1'b1;
        end else if (accept) begin
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            break_det   <= 1'b0;
            overrun     <= 1'b0;
        end
    end

endmodule
